// File: rtl/filter_pkg.sv
// Shared helpers for the filter bank: lane slicing, accumulator sizing,
// kernel load ordering and the pipeline control word.
package filter_pkg;

    typedef struct packed {
        logic val;
        logic last;
    } pipe_ctl_t;

    function automatic int acc_width(input int img_w, input int ker_w, input int taps);
        return img_w + ker_w + $clog2(taps);
    endfunction

    // Load order is g outer, then h, then w (w = 0 pairs with the newest column).
    function automatic int ker_idx(input int g, input int h, input int w,
                                   input int height_nb, input int width_nb);
        return (g * height_nb + h) * width_nb + w;
    endfunction

    function automatic int img_lo(input int h, input int img_w);
        return h * img_w;
    endfunction

    function automatic int ker_lo(input int w, input int ker_w);
        return w * ker_w;
    endfunction

    function automatic int res_lo(input int g, input int h, input int height_nb,
                                  input int acc_w);
        return (g * height_nb + h) * acc_w;
    endfunction

endpackage

// File: rtl/filter_lane.sv
// One row x one kernel multiply-accumulate: products registered in stage 1,
// their full-precision signed sum registered in stage 2.
module filter_lane
    import filter_pkg::*;
#(
    parameter int IMG_WIDTH = 16,
    parameter int KER_WIDTH = 8,
    parameter int WIDTH_NB  = 3,
    parameter int ACC_WIDTH = acc_width(IMG_WIDTH, KER_WIDTH, WIDTH_NB)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ld1_i,
    input  logic                          ld2_i,
    input  logic [WIDTH_NB*IMG_WIDTH-1:0] win_i,
    input  logic [WIDTH_NB*KER_WIDTH-1:0] ker_i,
    output logic [ACC_WIDTH-1:0]          acc_o
);
    localparam int PW = IMG_WIDTH + KER_WIDTH;

    logic signed [PW-1:0]        prod_q [WIDTH_NB];
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic signed [ACC_WIDTH-1:0] acc_d;

    always_comb begin
        acc_d = '0;
        for (int unsigned w = 0; w < WIDTH_NB; w++)
            acc_d = acc_d + ACC_WIDTH'(prod_q[w]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned w = 0; w < WIDTH_NB; w++) prod_q[w] <= '0;
            acc_q <= '0;
        end else begin
            if (ld1_i) begin
                for (int unsigned w = 0; w < WIDTH_NB; w++)
                    prod_q[w] <= PW'($signed(win_i[img_lo(int'(w), IMG_WIDTH) +: IMG_WIDTH]))
                               * PW'($signed(ker_i[ker_lo(int'(w), KER_WIDTH) +: KER_WIDTH]));
            end
            if (ld2_i) acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/filter_bank.sv
// Streaming row filter bank: GROUP_NB kernels over HEIGHT_NB parallel rows,
// double-buffered kernel load, line framing and a stallable 2-stage pipeline.
module filter_bank
    import filter_pkg::*;
#(
    parameter int GROUP_NB  = 4,
    parameter int HEIGHT_NB = 3,
    parameter int WIDTH_NB  = 3,
    parameter int IMG_WIDTH = 16,
    parameter int KER_WIDTH = 8,
    parameter int ACC_WIDTH = acc_width(IMG_WIDTH, KER_WIDTH, WIDTH_NB)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [KER_WIDTH-1:0]                   cfg_ker,
    input  logic                                   cfg_val,
    output logic                                   cfg_done,
    output logic                                   ker_pending,
    input  logic [HEIGHT_NB*IMG_WIDTH-1:0]         up_img,
    input  logic                                   up_val,
    input  logic                                   up_last,
    output logic                                   up_rdy,
    output logic [GROUP_NB*HEIGHT_NB*ACC_WIDTH-1:0] result,
    output logic                                   result_val,
    output logic                                   result_last,
    input  logic                                   result_rdy,
    output logic                                   short_line
);
    localparam int N    = GROUP_NB * HEIGHT_NB * WIDTH_NB;
    localparam int IDXW = $clog2(N);
    localparam int CW   = $clog2(WIDTH_NB + 1);

    logic [KER_WIDTH-1:0] shadow_q [N];
    logic [KER_WIDTH-1:0] active_q [N];
    logic [IDXW-1:0]      ld_idx_q;
    logic                 cfg_done_q, pending_q, short_q;
    logic [CW-1:0]        cnt_q, cnt_inc;
    logic [IMG_WIDTH-1:0] win_q [HEIGHT_NB][WIDTH_NB-1];
    logic [WIDTH_NB*IMG_WIDTH-1:0] win_cur [HEIGHT_NB];
    pipe_ctl_t            s1_q, s2_q;
    logic                 en, accept, commit, produce, load_last, ld1, ld2;

    assign en        = !s2_q.val || result_rdy;
    // Held low during reset so every output reads 0 while rst is asserted.
    assign up_rdy    = en && !rst;
    assign accept    = up_val && up_rdy;
    assign commit    = pending_q && (cnt_q == '0);
    assign cnt_inc   = (cnt_q == CW'(WIDTH_NB)) ? cnt_q : cnt_q + 1'b1;
    assign produce   = accept && (cnt_inc == CW'(WIDTH_NB));
    assign load_last = cfg_val && (ld_idx_q == IDXW'(N - 1));
    assign ld1       = en && produce;
    assign ld2       = en && s1_q.val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            ld_idx_q   <= '0;
            cfg_done_q <= 1'b0;
            pending_q  <= 1'b0;
        end else begin
            cfg_done_q <= load_last;
            if (cfg_val) begin
                shadow_q[ld_idx_q] <= cfg_ker;
                ld_idx_q <= load_last ? '0 : ld_idx_q + 1'b1;
            end
            if (commit)
                for (int unsigned i = 0; i < N; i++) active_q[i] <= shadow_q[i];
            // A completion landing on the commit cycle keeps the new bank pending.
            if (load_last)   pending_q <= 1'b1;
            else if (commit) pending_q <= 1'b0;
        end
    end

    always_comb begin
        for (int unsigned h = 0; h < HEIGHT_NB; h++) begin
            win_cur[h] = '0;
            win_cur[h][0 +: IMG_WIDTH] = up_img[img_lo(int'(h), IMG_WIDTH) +: IMG_WIDTH];
            for (int unsigned w = 1; w < WIDTH_NB; w++)
                win_cur[h][img_lo(int'(w), IMG_WIDTH) +: IMG_WIDTH] = win_q[h][w-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            short_q <= 1'b0;
            for (int unsigned h = 0; h < HEIGHT_NB; h++)
                for (int unsigned w = 0; w < WIDTH_NB - 1; w++) win_q[h][w] <= '0;
        end else if (accept) begin
            if (up_last) begin
                cnt_q <= '0;
                if (cnt_inc != CW'(WIDTH_NB)) short_q <= 1'b1;
                for (int unsigned h = 0; h < HEIGHT_NB; h++)
                    for (int unsigned w = 0; w < WIDTH_NB - 1; w++) win_q[h][w] <= '0;
            end else begin
                cnt_q <= cnt_inc;
                for (int unsigned h = 0; h < HEIGHT_NB; h++)
                    for (int unsigned w = 0; w < WIDTH_NB - 1; w++)
                        win_q[h][w] <= win_cur[h][img_lo(int'(w), IMG_WIDTH) +: IMG_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else if (en) begin
            s1_q.val  <= produce;
            s1_q.last <= produce && up_last;
            s2_q      <= s1_q;
        end
    end

    for (genvar g = 0; g < GROUP_NB; g++) begin : g_grp
        for (genvar h = 0; h < HEIGHT_NB; h++) begin : g_row
            logic [WIDTH_NB*KER_WIDTH-1:0] ker_lane;
            logic [ACC_WIDTH-1:0]          acc;

            // The column accepted on a commit cycle already sees the new bank.
            always_comb begin
                ker_lane = '0;
                for (int unsigned w = 0; w < WIDTH_NB; w++)
                    ker_lane[ker_lo(int'(w), KER_WIDTH) +: KER_WIDTH] = commit
                        ? shadow_q[ker_idx(g, h, int'(w), HEIGHT_NB, WIDTH_NB)]
                        : active_q[ker_idx(g, h, int'(w), HEIGHT_NB, WIDTH_NB)];
            end

            filter_lane #(
                .IMG_WIDTH(IMG_WIDTH),
                .KER_WIDTH(KER_WIDTH),
                .WIDTH_NB (WIDTH_NB),
                .ACC_WIDTH(ACC_WIDTH)
            ) u_lane (
                .clk  (clk),
                .rst  (rst),
                .ld1_i(ld1),
                .ld2_i(ld2),
                .win_i(win_cur[h]),
                .ker_i(ker_lane),
                .acc_o(acc)
            );

            assign result[res_lo(g, h, HEIGHT_NB, ACC_WIDTH) +: ACC_WIDTH] = acc;
        end
    end

    assign cfg_done    = cfg_done_q;
    assign ker_pending = pending_q;
    assign result_val  = s2_q.val;
    assign result_last = s2_q.last;
    assign short_line  = short_q;

endmodule

// File: tb/tb_filter_bank.sv
// Directed bench for filter_bank: kernel load/commit, streaming results,
// backpressure, framing, short lines and mid-line reset.
module tb_filter_bank;
    localparam int G = 4, H = 3, W = 3, IW = 16, KW = 8, ACC = 26, N = 36;
    localparam int RW = G * H * ACC;

    logic          clk = 1'b0;
    logic          rst, cfg_val, up_val, up_last, result_rdy;
    logic [KW-1:0] cfg_ker;
    logic [H*IW-1:0] up_img;
    logic          cfg_done, ker_pending, up_rdy, result_val, result_last, short_line;
    logic [RW-1:0] result;

    int checks = 0, errors = 0;
    int done_cnt = 0, hold_bad = 0, hold_seen = 0, rdy_bad = 0;
    logic watch_hold = 1'b0, held_v = 1'b0, toggle_en = 1'b0;
    logic [RW-1:0] held_r;
    logic [RW-1:0] rq[$];
    logic          lq[$];
    logic [KW-1:0] kbuf[N];

    filter_bank #(
        .GROUP_NB(G), .HEIGHT_NB(H), .WIDTH_NB(W),
        .IMG_WIDTH(IW), .KER_WIDTH(KW), .ACC_WIDTH(ACC)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_ker(cfg_ker), .cfg_val(cfg_val), .cfg_done(cfg_done), .ker_pending(ker_pending),
        .up_img(up_img), .up_val(up_val), .up_last(up_last), .up_rdy(up_rdy),
        .result(result), .result_val(result_val), .result_last(result_last),
        .result_rdy(result_rdy), .short_line(short_line)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && result_val && result_rdy) begin
            rq.push_back(result);
            lq.push_back(result_last);
        end
        if (cfg_done) done_cnt++;
        if (watch_hold) begin
            if (up_rdy !== (!result_val || result_rdy)) rdy_bad++;
            if (held_v) begin
                hold_seen++;
                if (result_val !== 1'b1 || result !== held_r) hold_bad++;
            end
            held_v = result_val && !result_rdy;
            held_r = result;
        end
    end

    function automatic logic [H*IW-1:0] col3(input int r0, input int r1, input int r2);
        logic [H*IW-1:0] v;
        v[0 +: IW]    = IW'(r0);
        v[IW +: IW]   = IW'(r1);
        v[2*IW +: IW] = IW'(r2);
        return v;
    endfunction

    function automatic logic [RW-1:0] lane_set(input logic [RW-1:0] base, input int g,
                                               input int h, input int v);
        logic [RW-1:0] r;
        r = base;
        r[(g*H+h)*ACC +: ACC] = ACC'(v);
        return r;
    endfunction

    function automatic logic [RW-1:0] all_groups(input int v0, input int v1, input int v2);
        logic [RW-1:0] r;
        r = '0;
        for (int g = 0; g < G; g++) begin
            r = lane_set(r, g, 0, v0);
            r = lane_set(r, g, 1, v1);
            r = lane_set(r, g, 2, v2);
        end
        return r;
    endfunction

    task automatic load_kernel(input int gap_after);
        for (int i = 0; i < N; i++) begin
            cfg_val = 1'b1;
            cfg_ker = kbuf[i];
            @(posedge clk); #1;
            if (i == gap_after) begin
                cfg_val = 1'b0;
                @(posedge clk); #1;
            end
        end
        cfg_val = 1'b0;
    endtask

    task automatic send_col(input logic [H*IW-1:0] img, input logic last);
        logic ok;
        ok = 1'b0;
        up_val = 1'b1; up_img = img; up_last = last;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (up_rdy) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        up_val = 1'b0; up_last = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_col_timeout up_rdy=%b required 1", up_rdy);
        end
    endtask

    task automatic stream_const(input int ncols);
        for (int c = 1; c <= ncols; c++) send_col(col3(24, 16, 8), c == ncols);
    endtask

    task automatic test_reset;
        rst = 1'b1; cfg_val = 1'b0; cfg_ker = '0; up_val = 1'b0; up_last = 1'b0;
        up_img = '0; result_rdy = 1'b1;
        repeat (3) @(posedge clk); #1;
        checks++;
        if ({cfg_done, ker_pending, up_rdy, result_val, result_last, short_line} !== 6'b0
            || result !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %b/%h required 0", {cfg_done, ker_pending, up_rdy,
                     result_val, result_last, short_line}, result);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (up_rdy !== 1'b1) begin errors++; $display("FAIL reset_uprdy got %b required 1", up_rdy); end
    endtask

    task automatic test_load;
        for (int i = 0; i < N; i++) kbuf[i] = 8'd8;
        done_cnt = 0; rq.delete(); lq.delete();
        load_kernel(3);
        checks++;
        if (cfg_done !== 1'b1 || ker_pending !== 1'b1) begin
            errors++;
            $display("FAIL load_done got done=%b pend=%b required 1 1", cfg_done, ker_pending);
        end
        @(posedge clk); #1;
        checks++;
        if (cfg_done !== 1'b0 || ker_pending !== 1'b0) begin
            errors++;
            $display("FAIL load_commit got done=%b pend=%b required 0 0", cfg_done, ker_pending);
        end
        repeat (4) @(posedge clk); #1;
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL load_pulses got %0d required 1", done_cnt); end
        checks++;
        if (rq.size() !== 0) begin errors++; $display("FAIL load_quiet got %0d results required 0", rq.size()); end
    endtask

    task automatic test_stream;
        logic [RW-1:0] e;
        e = all_groups(576, 384, 192);
        rq.delete(); lq.delete();
        for (int c = 1; c <= 10; c++) begin
            send_col(col3(24, 16, 8), c == 10);
            checks++;
            if (result_val !== logic'(c >= 4)) begin
                errors++;
                $display("FAIL stream_latency col=%0d got %b required %b", c, result_val, c >= 4);
            end
        end
        repeat (10) @(posedge clk); #1;
        checks++;
        if (rq.size() !== 8) begin errors++; $display("FAIL stream_count got %0d required 8", rq.size()); end
        for (int k = 0; k < 8 && k < rq.size(); k++) begin
            checks++;
            if (rq[k] !== e || lq[k] !== logic'(k == 7)) begin
                errors++;
                $display("FAIL stream_res k=%0d got %h last=%b required %h last=%b", k, rq[k], lq[k], e, k == 7);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [RW-1:0] e;
        e = all_groups(576, 384, 192);
        rq.delete(); lq.delete();
        hold_bad = 0; hold_seen = 0; rdy_bad = 0; held_v = 1'b0;
        watch_hold = 1'b1; toggle_en = 1'b1;
        fork
            while (toggle_en) begin
                @(posedge clk); #1;
                result_rdy = ~result_rdy;
            end
        join_none
        stream_const(10);
        repeat (20) @(posedge clk); #1;
        toggle_en = 1'b0;
        repeat (2) @(posedge clk); #1;
        result_rdy = 1'b1; watch_hold = 1'b0;
        repeat (4) @(posedge clk); #1;
        checks++;
        if (rq.size() !== 8) begin errors++; $display("FAIL bp_count got %0d required 8", rq.size()); end
        for (int k = 0; k < 8 && k < rq.size(); k++) begin
            checks++;
            if (rq[k] !== e || lq[k] !== logic'(k == 7)) begin
                errors++;
                $display("FAIL bp_res k=%0d got %h last=%b required %h last=%b", k, rq[k], lq[k], e, k == 7);
            end
        end
        checks++;
        if (hold_bad !== 0 || hold_seen == 0) begin
            errors++;
            $display("FAIL bp_hold got bad=%0d seen=%0d required 0 and >0", hold_bad, hold_seen);
        end
        checks++;
        if (rdy_bad !== 0) begin errors++; $display("FAIL bp_uprdy got %0d mismatches required 0", rdy_bad); end
    endtask

    task automatic test_ramp;
        logic [RW-1:0] e [3];
        int v00 [3] = '{10, 16, 22};
        int v11 [3] = '{1, 0, -1};
        for (int i = 0; i < N; i++) kbuf[i] = '0;
        kbuf[0]  = 8'd1;   kbuf[1]  = 8'd2;   kbuf[2]  = 8'd3;
        kbuf[12] = 8'hFF;  kbuf[13] = 8'd0;   kbuf[14] = 8'd2;
        kbuf[33] = 8'h80;  kbuf[34] = 8'h80;  kbuf[35] = 8'h80;
        load_kernel(-1);
        repeat (2) @(posedge clk); #1;
        for (int k = 0; k < 3; k++)
            e[k] = lane_set(lane_set(lane_set('0, 0, 0, v00[k]), 1, 1, v11[k]), 3, 2, 12582912);
        rq.delete(); lq.delete();
        for (int c = 1; c <= 5; c++) send_col(col3(c, -c, -32768), c == 5);
        repeat (6) @(posedge clk); #1;
        checks++;
        if (rq.size() !== 3) begin errors++; $display("FAIL ramp_count got %0d required 3", rq.size()); end
        for (int k = 0; k < 3 && k < rq.size(); k++) begin
            checks++;
            if (rq[k] !== e[k] || lq[k] !== logic'(k == 2)) begin
                errors++;
                $display("FAIL ramp_res k=%0d got %h required %h", k, rq[k], e[k]);
            end
        end
    endtask

    task automatic test_load_in_flight;
        logic [RW-1:0] e_old, e_new;
        e_old = lane_set(lane_set(lane_set('0, 0, 0, 144), 1, 1, 16), 3, 2, -3072);
        e_new = all_groups(576, 384, 192);
        for (int i = 0; i < N; i++) kbuf[i] = 8'd8;
        rq.delete(); lq.delete();
        fork
            begin
                load_kernel(-1);
                checks++;
                if (ker_pending !== 1'b1) begin
                    errors++;
                    $display("FAIL flight_pend_mid got %b required 1", ker_pending);
                end
            end
            for (int c = 1; c <= 40; c++) send_col(col3(24, 16, 8), c == 40);
        join
        checks++;
        if (ker_pending !== 1'b1) begin errors++; $display("FAIL flight_pend_last got %b required 1", ker_pending); end
        @(posedge clk); #1;
        checks++;
        if (ker_pending !== 1'b0) begin errors++; $display("FAIL flight_pend_idle got %b required 0", ker_pending); end
        stream_const(3);
        repeat (6) @(posedge clk); #1;
        checks++;
        if (rq.size() !== 39) begin errors++; $display("FAIL flight_count got %0d required 39", rq.size()); end
        for (int k = 0; k < 39 && k < rq.size(); k++) begin
            checks++;
            if (rq[k] !== ((k < 38) ? e_old : e_new) || lq[k] !== logic'(k >= 37)) begin
                errors++;
                $display("FAIL flight_res k=%0d got %h last=%b required %h", k, rq[k], lq[k],
                         (k < 38) ? e_old : e_new);
            end
        end
    endtask

    task automatic test_short_and_reset;
        rq.delete(); lq.delete();
        checks++;
        if (short_line !== 1'b0) begin errors++; $display("FAIL short_pre got %b required 0", short_line); end
        send_col(col3(24, 16, 8), 1'b0);
        send_col(col3(24, 16, 8), 1'b1);
        repeat (5) @(posedge clk); #1;
        checks++;
        if (rq.size() !== 0 || short_line !== 1'b1) begin
            errors++;
            $display("FAIL short_line got n=%0d sticky=%b required 0 1", rq.size(), short_line);
        end
        for (int c = 1; c <= 4; c++) send_col(col3(24, 16, 8), 1'b0);
        checks++;
        if (result_val !== 1'b1) begin errors++; $display("FAIL midline_val got %b required 1", result_val); end
        rst = 1'b1;
        #1;
        checks++;
        if ({cfg_done, ker_pending, up_rdy, result_val, result_last, short_line} !== 6'b0
            || result !== '0) begin
            errors++;
            $display("FAIL midline_reset got %b/%h required 0", {cfg_done, ker_pending, up_rdy,
                     result_val, result_last, short_line}, result);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        rq.delete(); lq.delete();
        stream_const(5);
        repeat (6) @(posedge clk); #1;
        checks++;
        if (rq.size() !== 3) begin errors++; $display("FAIL post_reset_count got %0d required 3", rq.size()); end
        for (int k = 0; k < 3 && k < rq.size(); k++) begin
            checks++;
            if (rq[k] !== '0 || lq[k] !== logic'(k == 2)) begin
                errors++;
                $display("FAIL post_reset_res k=%0d got %h last=%b required 0 last=%b", k, rq[k], lq[k], k == 2);
            end
        end
    endtask

    initial begin
        test_reset;
        test_load;
        test_stream;
        test_backpressure;
        test_ramp;
        test_load_in_flight;
        test_short_and_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running required finished");
        $fatal(1);
    end

endmodule
